// File: rtl/riscp_pkg.sv
// Shared sequencer types: state encoding, opcode constants and opcode-class helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package riscp_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Opcode values (4-bit field of IR); 0x0-0x7 are ALU operations
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_RSV0 = 4'hC;
    localparam logic [3:0] OP_RSV1 = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // ALU group: register-to-register operations that write back a result
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= 4'h7);
    endfunction

    // Loads and stores need a data-memory phase
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // NOP and the reserved codes skip execution entirely
    function automatic logic is_nop_op(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_RSV0) || (op == OP_RSV1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without mem_ack; flags expiry.
// Latency: expired is combinational in the TIMEOUT-th unacknowledged wait cycle.
// Backpressure: none; the counter clears whenever the sequencer is not waiting or ack arrives.
module mem_wait_timer
    import riscp_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic pclk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Count wait cycles; leaving the wait state clears, so every FETCH/MEM entry starts at 0
    always_ff @(posedge pclk) begin
        if (rst || !active || ack) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = active && !ack && (cnt == LAST);

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes and retire counter.
// Latency: ALU/JMP/BZ 4 cycles, LD/ST 5, NOP 3 with zero-wait memory; controls decode from the state register.
// Backpressure: FETCH and MEM hold mem_req until mem_ack; MEM_TIMEOUT_EN bounds the wait and halts with fault.
module instr_seq_ctrl
    import riscp_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int CNT_W = 16
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             alu_en,
    output logic             reg_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    logic [3:0] op;
    logic       tmo;

    assign op = 4'(opcode);

`ifdef MEM_TIMEOUT_EN
    logic waiting;
    logic fault_q;

    assign waiting = (state == S_FETCH) || (state == S_MEM);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .pclk    (pclk),
        .rst     (rst),
        .active  (waiting),
        .ack     (mem_ack),
        .expired (tmo)
    );

    // Fault latches on the first expiry and holds until reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (tmo) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign tmo   = 1'b0;
    assign fault = 1'b0;
`endif

    // State sequencing and retire counting; HALT is only left through reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= S_IDLE;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack)  state <= S_DECODE;
                    else if (tmo) state <= S_HALT;
                end
                S_DECODE: begin
                    if (op == OP_HLT)      state <= S_HALT;
                    else if (is_nop_op(op)) state <= S_WB;
                    else                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_mem_op(op)) state <= S_MEM;
                    else               state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ack)  state <= S_WB;
                    else if (tmo) state <= S_HALT;
                end
                S_WB: begin
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Control strobes decoded from the registered state (opcode/zero/ack qualify some)
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        halted  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ld_ir   = mem_ack;
            end
            S_DECODE: begin
                inc_pc = 1'b1;
            end
            S_EXEC: begin
                alu_en = is_alu_op(op) || is_mem_op(op);
                ld_pc  = (op == OP_JMP) || ((op == OP_BZ) && zero);
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op == OP_ST);
            end
            S_WB: begin
                reg_we = is_alu_op(op) || (op == OP_LD);
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
